// File: rtl/qsys_pio_out_pulse.sv
// qsys_pio_out_pulse
// Avalon-MM output PIO for board-control lines (supply enables, resets,
// LEDs, straps). Provides a RW data register, atomic SET/CLEAR/TOGGLE
// write ports, and a one-shot pulse timer that inverts a masked subset of
// the outputs for a programmed number of clocks.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous, active-high reset
//   address    - word address (0 DATA, 1 SET, 2 CLEAR, 3 TOGGLE,
//                4 PULSE, 5 PULSE_LEN, 6 STATUS, 7 reserved)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - write data
//   readdata   - read data, combinational from address
//   out_port   - registered output pins, data_q ^ mask_q
module qsys_pio_out_pulse #(
   parameter int               WIDTH       = 5,
   parameter logic [WIDTH-1:0] RESET_VALUE = '0,
   parameter int               CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port
);

   localparam logic [2:0] A_DATA   = 3'd0;
   localparam logic [2:0] A_SET    = 3'd1;
   localparam logic [2:0] A_CLEAR  = 3'd2;
   localparam logic [2:0] A_TOGGLE = 3'd3;
   localparam logic [2:0] A_PULSE  = 3'd4;
   localparam logic [2:0] A_LEN    = 3'd5;
   localparam logic [2:0] A_STATUS = 3'd6;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef enum logic {IDLE, ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] data_q,  data_d;
   logic [WIDTH-1:0] mask_q,  mask_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [CNT_W-1:0] len_q,   len_d;
   logic             err_q,   err_d;
   logic [WIDTH-1:0] out_q;

   logic             wr;
   logic [WIDTH-1:0] wd;
   logic             unused_wd;

   assign wr = chipselect && !write_n;
   assign wd = writedata[WIDTH-1:0];
   // Upper writedata bits are architecturally ignored.
   assign unused_wd = ^writedata;

   // ----------------------------------------------------------------
   // State register
   // ----------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         data_q  <= RESET_VALUE;
         mask_q  <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         err_q   <= 1'b0;
         out_q   <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         len_q   <= len_d;
         err_q   <= err_d;
         // Output is built from next-state values so it is a clean flop
         // that still shows a write at the first edge after it.
         out_q   <= data_d ^ mask_d;
      end
   end

   assign out_port = out_q;

   // ----------------------------------------------------------------
   // Next-state logic: data register, pulse FSM, length, error flag
   // ----------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      err_d   = err_q;

      // Data register ports stay live during a pulse.
      if (wr) begin
         case (address)
            A_DATA:   data_d = wd;
            A_SET:    data_d = data_q | wd;
            A_CLEAR:  data_d = data_q & ~wd;
            A_TOGGLE: data_d = data_q ^ wd;
            A_LEN:    len_d  = writedata[CNT_W-1:0];
            default:  ;
         endcase
      end

      // Clear first so a same-cycle set takes precedence.
      if (wr && address == A_STATUS && writedata[1])
         err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (wr && address == A_PULSE && wd != '0) begin
               state_d = ACTIVE;
               mask_d  = wd;
               // A zero length still produces a single-cycle pulse.
               cnt_d   = (len_q == '0) ? CNT_ONE : len_q;
            end
         end
         ACTIVE: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = IDLE;
               mask_d  = '0;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_ONE;
            end
            // Re-arming a running pulse is rejected and flagged.
            if (wr && address == A_PULSE)
               err_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            mask_d  = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // ----------------------------------------------------------------
   // Read mux, zero latency; write-only and reserved words read 0
   // ----------------------------------------------------------------
   always_comb begin
      readdata = '0;
      case (address)
         A_DATA:   readdata[WIDTH-1:0] = data_q;
         A_PULSE:  readdata[WIDTH-1:0] = mask_q;
         A_LEN:    readdata[CNT_W-1:0] = len_q;
         A_STATUS: readdata[1:0]       = {err_q, state_q == ACTIVE};
         default:  readdata = '0;
      endcase
   end

endmodule

// File: tb/tb_qsys_pio_out_pulse.sv
module tb_qsys_pio_out_pulse;

   localparam int         WIDTH = 5;
   localparam logic [4:0] RV    = 5'h15;
   localparam int         CNT_W = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [WIDTH-1:0] out_port;

   int n_cmp = 0;
   int n_bad = 0;

   qsys_pio_out_pulse #(.WIDTH(WIDTH), .RESET_VALUE(RV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
      .write_n(write_n), .writedata(writedata), .readdata(readdata),
      .out_port(out_port)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: the write occupies the current cycle and the
   // task returns at the negedge of the following cycle.
   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      @(negedge clk);
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   task automatic rchk(input string tag, input logic [2:0] a, input logic [31:0] exp);
      address = a;
      #1;
      chk(tag, readdata, exp);
   endtask

   task automatic ochk(input string tag, input logic [4:0] exp);
      chk(tag, 32'(out_port), 32'(exp));
   endtask

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
      cyc(3);
      reset = 1'b0;

      // Reset state
      ochk("rst_out", 5'h15);
      rchk("rst_data", 3'd0, 32'h15);
      rchk("rst_pulse", 3'd4, 32'h0);
      rchk("rst_len", 3'd5, 32'h0);
      rchk("rst_status", 3'd6, 32'h0);
      rchk("rst_set", 3'd1, 32'h0);
      rchk("rst_res7", 3'd7, 32'h0);

      // Upper writedata bits ignored
      @(negedge clk);
      wr(3'd0, 32'hFFFF_FFE0);
      ochk("data_upper_out", 5'h00);
      rchk("data_upper_rd", 3'd0, 32'h0);

      // Atomic ports
      @(negedge clk);
      wr(3'd0, 32'h0A);  ochk("data_0a", 5'h0A);
      wr(3'd1, 32'h11);  ochk("set_11", 5'h1B);
      rchk("set_rd0", 3'd1, 32'h0);
      @(negedge clk);
      wr(3'd2, 32'h03);  ochk("clr_03", 5'h18);
      rchk("clr_rd0", 3'd2, 32'h0);
      @(negedge clk);
      wr(3'd3, 32'h1F);  ochk("tgl_1f", 5'h07);
      rchk("tgl_rd0", 3'd3, 32'h0);
      rchk("data_after_tgl", 3'd0, 32'h07);
      @(negedge clk);
      wr(3'd7, 32'hFF);  ochk("res7_wr_out", 5'h07);
      rchk("res7_rd", 3'd7, 32'h0);

      // 3-cycle pulse
      @(negedge clk);
      wr(3'd5, 32'd3);
      rchk("len3_rd", 3'd5, 32'd3);
      @(negedge clk);
      wr(3'd0, 32'h0);
      wr(3'd4, 32'h04);                 // cycle T, now in T+1
      ochk("p3_t1_out", 5'h04);
      rchk("p3_t1_busy", 3'd6, 32'h1);
      rchk("p3_t1_mask", 3'd4, 32'h04);
      @(negedge clk);
      ochk("p3_t2_out", 5'h04);
      rchk("p3_t2_busy", 3'd6, 32'h1);
      @(negedge clk);
      ochk("p3_t3_out", 5'h04);
      rchk("p3_t3_busy", 3'd6, 32'h1);
      @(negedge clk);
      ochk("p3_t4_out", 5'h00);
      rchk("p3_t4_busy", 3'd6, 32'h0);
      rchk("p3_t4_mask", 3'd4, 32'h0);

      // Zero length gives one cycle; zero mask does nothing
      @(negedge clk);
      wr(3'd5, 32'd0);
      wr(3'd4, 32'h01);
      ochk("p0_t1_out", 5'h01);
      rchk("p0_t1_busy", 3'd6, 32'h1);
      @(negedge clk);
      ochk("p0_t2_out", 5'h00);
      rchk("p0_t2_busy", 3'd6, 32'h0);
      @(negedge clk);
      wr(3'd4, 32'h00);
      ochk("pz_out", 5'h00);
      rchk("pz_status", 3'd6, 32'h0);

      // Rejected re-arm while active, data writes during pulse
      @(negedge clk);
      wr(3'd5, 32'd10);
      wr(3'd4, 32'h02);                 // T, now in T+1
      ochk("p10_t1_out", 5'h02);
      cyc(3);                           // T+4
      wr(3'd4, 32'h08);                 // rejected, now T+5
      ochk("p10_t5_out", 5'h02);
      rchk("p10_t5_status", 3'd6, 32'h3);
      rchk("p10_t5_mask", 3'd4, 32'h02);
      @(negedge clk);
      wr(3'd0, 32'h10);                 // written in T+6, now T+7
      ochk("p10_t7_out", 5'h12);
      cyc(3);                           // T+10
      ochk("p10_t10_out", 5'h12);
      rchk("p10_t10_status", 3'd6, 32'h3);
      @(negedge clk);                   // T+11
      ochk("p10_t11_out", 5'h10);
      rchk("p10_t11_status", 3'd6, 32'h2);
      @(negedge clk);
      wr(3'd6, 32'h2);
      rchk("err_clr", 3'd6, 32'h0);

      // Reset aborts a long pulse
      @(negedge clk);
      wr(3'd5, 32'd100);
      wr(3'd0, 32'h00);
      wr(3'd4, 32'h1F);                 // T, now T+1
      ochk("p100_t1_out", 5'h1F);
      cyc(19);                          // T+20
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      ochk("abort_out", RV);
      rchk("abort_status", 3'd6, 32'h0);
      rchk("abort_len", 3'd5, 32'h0);
      rchk("abort_mask", 3'd4, 32'h0);
      cyc(5);
      ochk("abort_later_out", RV);
      rchk("abort_later_status", 3'd6, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
